// File: rtl/buffer_meta_rw.sv
// buffer_meta_rw
//   Writable meta/constant buffer for one PE: a RAM of 2^addrLen words of
//   dataLen bits. It replaces the fixed per-PE constant ROM.
//   After reset the buffer rewrites its own contents: word 0 = INIT_WORD0,
//   every other word = 0. It can then be bulk-loaded through a valid/ready
//   stream and updated word by word by the PE. Reads have one cycle of latency.
//
// Ports
//   clk        clock, all logic on rising edge
//   reset      asynchronous active-low reset
//   init_busy  high while self-init is running
//   rd_en      read request; rd_addr is the read address
//   data_out   registered read data
//   rd_valid   data_out was updated by an accepted read
//   wr_en      PE write request; wr_addr/wr_data are the address and data
//   wr_drop    one-cycle pulse: a PE write was lost to a load in the same cycle
//   ld_valid   load word valid; ld_data is the word; ld_last marks the last word
//   ld_ready   buffer accepts load words (high in RUN)
//   ld_done    one-cycle pulse after the last word of a burst is written
//
// state   | meaning
// ST_INIT | rewriting the memory, one word per cycle; all requests ignored
// ST_RUN  | normal operation: loads, PE writes, reads

module buffer_meta_rw #(
    parameter int                 addrLen    = 6,
    parameter int                 dataLen    = 16,
    parameter int                 peId       = 0,
    parameter logic [dataLen-1:0] INIT_WORD0 = dataLen'(1)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               init_busy,
    input  logic               rd_en,
    input  logic [addrLen-1:0] rd_addr,
    output logic [dataLen-1:0] data_out,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [addrLen-1:0] wr_addr,
    input  logic [dataLen-1:0] wr_data,
    output logic               wr_drop,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [dataLen-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_done
);

    localparam int DEPTH = 1 << addrLen;

    // peId only labels the instance and does not change behaviour
    if (peId < 0) begin : g_pe_chk
        $error("buffer_meta_rw: peId must be non-negative");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state;
    logic [addrLen-1:0] init_cnt;
    logic [addrLen-1:0] ld_ptr;
    logic [dataLen-1:0] mem [DEPTH];

    logic               ld_hs;
    logic               mem_we;
    logic [addrLen-1:0] mem_waddr;
    logic [dataLen-1:0] mem_wdata;

    assign ld_ready  = (state == ST_RUN);
    assign init_busy = (state == ST_INIT);
    assign ld_hs     = ld_valid & ld_ready;

    // Single write port. Priority: self-init, then load, then PE write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = (init_cnt == '0) ? INIT_WORD0 : '0;
        end else if (ld_hs) begin
            mem_we    = 1'b1;
            mem_waddr = ld_ptr;
            mem_wdata = ld_data;
        end else if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Storage has no reset; self-init rewrites every word after reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ld_ptr   <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            ld_done  <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            ld_done  <= 1'b0;
            wr_drop  <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == addrLen'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ld_hs) begin
                        ld_ptr  <= ld_last ? '0 : ld_ptr + 1'b1;
                        ld_done <= ld_last;
                        wr_drop <= wr_en;
                    end
                    if (rd_en) begin
                        rd_valid <= 1'b1;
                        // Write-first: a write committed this cycle to the
                        // read address is returned instead of the old word.
                        data_out <= (mem_we && mem_waddr == rd_addr) ?
                                    mem_wdata : mem[rd_addr];
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_meta_rw.sv
module tb_buffer_meta_rw;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_busy;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_drop;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buffer_meta_rw #(
        .addrLen(6), .dataLen(16), .peId(0), .INIT_WORD0(16'h0001)
    ) dut (
        .clk(clk), .reset(reset), .init_busy(init_busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .ld_done(ld_done)
    );

    // One cycle step: inputs change 1 time unit after the rising edge,
    // outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0;
        repeat (3) step();
        n_checks++; if (init_busy !== 1'b1) begin n_fail++; $display("FAIL rst_init_busy got %b exp 1", init_busy); end
        n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data_out got %h exp 0000", data_out); end
        n_checks++; if ({rd_valid, ld_ready, ld_done, wr_drop} !== 4'b0) begin n_fail++;
            $display("FAIL rst_flags got %b exp 0000", {rd_valid, ld_ready, ld_done, wr_drop}); end
    endtask

    task automatic test_init();
        int busy_cnt = 0;
        int guard = 0;
        rd_en = 1'b1; rd_addr = 6'd0;
        reset = 1'b1;
        while (init_busy && guard < 200) begin
            busy_cnt++;
            n_checks++; if (rd_valid !== 1'b0 || ld_ready !== 1'b0) begin n_fail++;
                $display("FAIL init_quiet cycle %0d got rd_valid=%b ld_ready=%b exp 0 0", busy_cnt, rd_valid, ld_ready); end
            step();
            guard++;
        end
        n_checks++; if (busy_cnt !== 64) begin n_fail++; $display("FAIL init_len got %0d exp 64", busy_cnt); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL init_last_rd got %b exp 0", rd_valid); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL run_ld_ready got %b exp 1", ld_ready); end
        step();
        n_checks++; if (data_out !== 16'h0001 || rd_valid !== 1'b1) begin n_fail++;
            $display("FAIL first_rd0 got %h/%b exp 0001/1", data_out, rd_valid); end
        rd_en = 1'b0;
        do_read(6'd5);
        n_checks++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_fail++;
            $display("FAIL rd5 got %h/%b exp 0000/1", data_out, rd_valid); end
        step();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_idle got %b exp 0", rd_valid); end
    endtask

    task automatic test_load_burst();
        logic [15:0] exp_w [4] = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = exp_w[i]; ld_last = (i == 3);
            step();
            n_checks++; if (ld_done !== (i == 3)) begin n_fail++;
                $display("FAIL ld_done word %0d got %b exp %b", i, ld_done, (i == 3)); end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        step();
        n_checks++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL ld_done_pulse got %b exp 0", ld_done); end
        for (int i = 0; i < 4; i++) begin
            do_read(6'(i));
            n_checks++; if (data_out !== exp_w[i]) begin n_fail++;
                $display("FAIL burst_rd%0d got %h exp %h", i, data_out, exp_w[i]); end
        end
        ld_valid = 1'b1; ld_data = 16'h00B0; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++; if (ld_done !== 1'b1) begin n_fail++; $display("FAIL burst2_done got %b exp 1", ld_done); end
        do_read(6'd0);
        n_checks++; if (data_out !== 16'h00B0) begin n_fail++; $display("FAIL burst2_rd0 got %h exp 00B0", data_out); end
        do_read(6'd1);
        n_checks++; if (data_out !== 16'h00A1) begin n_fail++; $display("FAIL burst2_rd1 got %h exp 00A1", data_out); end
    endtask

    task automatic test_write_first();
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'h1234;
        rd_en = 1'b1; rd_addr = 6'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (data_out !== 16'h1234 || rd_valid !== 1'b1) begin n_fail++;
            $display("FAIL wf_same got %h/%b exp 1234/1", data_out, rd_valid); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL wf_no_drop got %b exp 0", wr_drop); end
        do_read(6'd6);
        do_read(6'd7);
        n_checks++; if (data_out !== 16'h1234) begin n_fail++; $display("FAIL wf_later got %h exp 1234", data_out); end
    endtask

    task automatic test_collision();
        ld_valid = 1'b1; ld_data = 16'h0050; step();
        ld_data = 16'h0051; step();
        ld_data = 16'h0055;
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 16'h0077;
        step();
        wr_en = 1'b0; ld_valid = 1'b0;
        n_checks++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL col_drop got %b exp 1", wr_drop); end
        step();
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL col_drop_pulse got %b exp 0", wr_drop); end
        do_read(6'd2);
        n_checks++; if (data_out !== 16'h0055) begin n_fail++; $display("FAIL col_rd2 got %h exp 0055", data_out); end
        do_read(6'd9);
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL col_rd9 got %h exp 0000", data_out); end
        ld_valid = 1'b1; ld_data = 16'h0056; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++; if (ld_done !== 1'b1) begin n_fail++; $display("FAIL col_close got %b exp 1", ld_done); end
    endtask

    task automatic test_wrap();
        int done_seen = 0;
        for (int i = 0; i < 65; i++) begin
            ld_valid = 1'b1; ld_data = 16'h0100 + 16'(i); ld_last = 1'b0;
            step();
            if (ld_done) done_seen++;
        end
        ld_valid = 1'b0;
        step();
        if (ld_done) done_seen++;
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL wrap_no_done got %0d exp 0", done_seen); end
        do_read(6'd0);
        n_checks++; if (data_out !== 16'h0140) begin n_fail++; $display("FAIL wrap_rd0 got %h exp 0140", data_out); end
        do_read(6'd63);
        n_checks++; if (data_out !== 16'h013F) begin n_fail++; $display("FAIL wrap_rd63 got %h exp 013F", data_out); end
        do_read(6'd1);
        n_checks++; if (data_out !== 16'h0101) begin n_fail++; $display("FAIL wrap_rd1 got %h exp 0101", data_out); end
    endtask

    task automatic test_reset_midburst();
        int guard = 0;
        int done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 16'h00C0 + 16'(i);
            step();
        end
        ld_data = 16'h00C3;
        #3 reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 16'h0000 || ld_ready !== 1'b0 || init_busy !== 1'b1) begin n_fail++;
            $display("FAIL async_rst got data=%h ready=%b busy=%b exp 0000 0 1", data_out, ld_ready, init_busy); end
        ld_valid = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        while (init_busy && guard < 200) begin
            step();
            if (ld_done) done_seen++;
            guard++;
        end
        n_checks++; if (init_busy !== 1'b0 || done_seen !== 0) begin n_fail++;
            $display("FAIL reinit got busy=%b done_pulses=%0d exp 0 0", init_busy, done_seen); end
        do_read(6'd1);
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reinit_rd1 got %h exp 0000", data_out); end
        do_read(6'd2);
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reinit_rd2 got %h exp 0000", data_out); end
        do_read(6'd0);
        n_checks++; if (data_out !== 16'h0001) begin n_fail++; $display("FAIL reinit_rd0 got %h exp 0001", data_out); end
        ld_valid = 1'b1; ld_data = 16'h00D0; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        do_read(6'd0);
        n_checks++; if (data_out !== 16'h00D0) begin n_fail++; $display("FAIL reld_rd0 got %h exp 00D0", data_out); end
        do_read(6'd1);
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reld_rd1 got %h exp 0000", data_out); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_load_burst();
        test_write_first();
        test_collision();
        test_wrap();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_meta_rw.md
Name: buffer_meta_rw

Overview:
Per-PE writable meta/constant buffer. It replaces the fixed per-peId constant ROM with a parametrised RAM of 2^addrLen words. After reset it self-initialises (word 0 = INIT_WORD0, all other words = 0). It can then be bulk-loaded from the memory interface through a valid/ready stream and updated by the PE. Reads have a registered output with one-cycle latency, as the PE datapath expects.

Parameters:
addrLen, 6, address width; DEPTH = 2^addrLen words
dataLen, 16, word width
peId, 0, PE index; informational only, carries no behaviour
INIT_WORD0, 1, value written to address 0 during self-init (set to 0 to disable)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
init_busy  output  1  high while self-init is in progress
rd_en  input  1  read request
rd_addr  input  addrLen  read address
data_out  output  dataLen  registered read data
rd_valid  output  1  data_out updated this cycle from an accepted read
wr_en  input  1  PE write request
wr_addr  input  addrLen  PE write address
wr_data  input  dataLen  PE write data
wr_drop  output  1  one-cycle pulse: PE write lost to a load collision
ld_valid  input  1  load word valid
ld_ready  output  1  buffer can accept a load word
ld_data  input  dataLen  load word
ld_last  input  1  qualifies the final word of a load burst
ld_done  output  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (reset==0, async): state=INIT, init_cnt=0, ld_ptr=0, data_out=0, rd_valid=0, ld_ready=0, ld_done=0, wr_drop=0, init_busy=1. Memory contents are not reset directly; INIT rewrites them.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes mem[init_cnt] = (init_cnt==0) ? INIT_WORD0 : 0, then init_cnt++.
  - When init_cnt==DEPTH-1 is written, next state is RUN.
  - Self-init takes exactly DEPTH cycles after reset deassertion.
  - rd_en, wr_en and ld_valid are ignored: no drop pulse, ld_ready=0, rd_valid=0, data_out holds.
- RUN:
  - init_busy=0.
  - ld_ready=1 combinationally in RUN; it never deasserts in RUN.
- Load:
  - On ld_valid&ld_ready: mem[ld_ptr] <= ld_data.
  - If ld_last: ld_ptr <= 0 and ld_done=1 the next cycle. Otherwise ld_ptr++, wrapping DEPTH-1 -> 0 silently.
- PE write:
  - wr_en writes mem[wr_addr] <= wr_data only if no load handshake occurs in the same cycle.
  - If both occur, the load wins, the PE write is discarded, and wr_drop=1 the next cycle. This applies regardless of address.
- Read:
  - rd_en in RUN gives data_out <= mem[rd_addr] and rd_valid=1 on the next edge (latency 1).
  - Without rd_en: data_out holds and rd_valid=0.
  - Write-first: if a committed write (load or PE) in the same cycle targets rd_addr, data_out takes the new write data.
- Reset during a load burst: the burst is abandoned, ld_ptr returns to 0, and INIT rewrites the whole memory. No ld_done is generated.
- Transition INIT->RUN: a read issued in the first RUN cycle returns post-init contents.
- ld_done, wr_drop and rd_valid are registered single-cycle pulses.
- Widths: addresses wrap modulo DEPTH. No arithmetic is performed on data.

Test Plan:
1. Release reset, rd_en each cycle. Required: init_busy high for exactly 64 cycles, rd_valid=0 throughout INIT. First RUN read of addr 0 returns 0x0001; addr 5 returns 0x0000.
2. Stream 4 words 0xA0..0xA3, ld_last on the 4th. Required: ld_done pulses once, one cycle after the 4th handshake. Reads of addrs 0..3 return 0xA0..0xA3. A second burst starts again at addr 0.
3. In the same cycle: wr_en to addr 7 with 0x1234 and rd_en addr 7. Required: data_out=0x1234, rd_valid=1 next cycle. A later read of addr 7 also returns 0x1234.
4. Same-cycle load handshake (ld_ptr=2, data 0x55) and PE write to addr 9 (0x77). Required: addr 2 = 0x55, addr 9 unchanged (0), wr_drop=1 for one cycle.
5. 65 load words with no ld_last. Required: ld_ptr wraps, addr 0 holds word 64, no ld_done pulse.
6. Assert reset mid-burst after 3 words. Required: data_out=0 and ld_ready=0 immediately (async). After re-init, addrs 1..2 read 0, addr 0 reads INIT_WORD0, and the next load starts at addr 0.
